wb_prefetch: RTL and testbench

//  Wishbone classic-pipelined read master that streams 16-bit J1 instruction words from the ROM slave into a small FIFO.

---
 rtl/j1_wb_pkg.sv | 19 +
 rtl/wb_prefetch_fifo.sv | 80 ++++++++
 rtl/wb_prefetch.sv | 130 +++++++++++++
 tb/tb_wb_prefetch.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/j1_wb_pkg.sv
// Purpose: shared types for the J1 instruction-fetch path (ROM word, address, fetched entry).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package j1_wb_pkg;

    localparam int unsigned WORD_W = 16;
    // Word-address width of the 8192x16 instruction ROM.
    localparam int unsigned ROM_AW = 13;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [ROM_AW-1:0] addr_t;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        addr_t pc;
        word_t data;
    } fetch_t;

endpackage

// File: rtl/wb_prefetch_fifo.sv
// Purpose: small instruction buffer between the Wishbone read path and the CPU fetch port.
// Latency: a pushed word is visible at the output the cycle after the push (no bypass).
// Backpressure: pop only when valid; the caller guarantees no push while full; flush beats push/pop.
//
// Ports:
//   clk, rst_n    clock, async active-low reset
//   flush_i       synchronous clear of all entries
//   push_i/_dat_i write one entry at the tail
//   pop_i         consume the head entry (ignored when empty)
//   pop_vld_o     head entry valid; pop_dat_o is the head entry
//   count_o       number of stored entries
module wb_prefetch_fifo
    import j1_wb_pkg::*;
#(
    parameter int unsigned  DEPTH = 4,
    parameter type          T     = fetch_t,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  T                 push_dat_i,
    input  logic             pop_i,
    output logic             pop_vld_o,
    output T                 pop_dat_o,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_ok;
    T                 mem_q [DEPTH];

    always_comb begin
        pop_ok   = pop_i && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count_q gates every read.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign pop_vld_o = (count_q != '0);
    assign pop_dat_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (push_i && !flush_i) |-> (count_q != FULL));

endmodule

// File: rtl/wb_prefetch.sv
// Purpose: Wishbone pipelined read master streaming J1 instruction words from ROM into a FIFO.
// Latency: stb at N, ack at N+1 (1-cycle ROM), insn_valid at N+2; redirect at R -> stb R+1, insn R+3.
// Backpressure: issues only while (outstanding + buffered) < DEPTH; wb_stall_i holds the request.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   redirect_valid/redirect_pc  branch redirect: flush and restart fetch at redirect_pc
//   insn_valid/ready/data/pc    instruction stream to the CPU (valid/ready)
//   wb_cyc_o/stb_o/adr_o        Wishbone read request (pipelined)
//   wb_dat_i/ack_i/stall_i      Wishbone response and stall
module wb_prefetch
    import j1_wb_pkg::*;
#(
    parameter int unsigned   AW       = ROM_AW,
    parameter int unsigned   DEPTH    = 4,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          insn_valid,
    input  logic          insn_ready,
    output word_t         insn_data,
    output logic [AW-1:0] insn_pc,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic [AW-1:0] wb_adr_o,
    input  word_t         wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_stall_i
);

    localparam int unsigned      CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned      SUM_W   = CNT_W + 1;
    localparam logic [SUM_W-1:0] CREDITS = SUM_W'(DEPTH);
    localparam logic [CNT_W-1:0] MAX_OUT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [AW-1:0] pc;
        word_t         data;
    } entry_t;

    logic [AW-1:0]    adr_q, adr_d;
    logic [AW-1:0]    resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic             run_q;
    logic [CNT_W-1:0] fifo_count;
    logic             stb, accept, ack_ok, push, pop;
    entry_t           push_dat, head;

    always_comb begin
        // Acks with nothing outstanding are protocol errors and are ignored.
        ack_ok = wb_ack_i && (outstanding_q != '0);
        // Credit uses registered counts only, so a same-cycle pop frees nothing yet.
        // run_q keeps the bus quiet until the first edge after reset release.
        stb    = run_q && !redirect_valid &&
                 ((SUM_W'(outstanding_q) + SUM_W'(fifo_count)) < CREDITS);
        accept = stb && !wb_stall_i;
        // An ack arriving with a redirect belongs to the old stream and is dropped.
        push   = ack_ok && (discard_q == '0) && !redirect_valid;
        pop    = insn_valid && insn_ready;

        push_dat.pc   = resp_pc_q;
        push_dat.data = wb_dat_i;

        outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(ack_ok);
        adr_d         = adr_q;
        resp_pc_d     = resp_pc_q;
        discard_d     = discard_q;

        if (redirect_valid) begin
            adr_d     = redirect_pc;
            resp_pc_d = redirect_pc;
            // Everything still owed by the slave after this cycle is stale.
            discard_d = outstanding_d;
        end else begin
            if (accept) adr_d = adr_q + AW'(1);
            if (ack_ok && (discard_q != '0)) discard_d = discard_q - CNT_W'(1);
            if (push) resp_pc_d = resp_pc_q + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adr_q         <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            run_q         <= 1'b0;
        end else begin
            adr_q         <= adr_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            run_q         <= 1'b1;
        end
    end

    wb_prefetch_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (redirect_valid),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .pop_vld_o  (insn_valid),
        .pop_dat_o  (head),
        .count_o    (fifo_count)
    );

    assign wb_stb_o  = stb;
    // Cycle stays up while any ack is still due, even with no new request.
    assign wb_cyc_o  = stb || (outstanding_q != '0);
    assign wb_adr_o  = adr_q;
    assign insn_data = head.data;
    assign insn_pc   = head.pc;

    a_outstanding_max: assert property (@(posedge clk) disable iff (!rst_n)
        outstanding_q <= MAX_OUT);
    a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (wb_stb_o && wb_stall_i && !redirect_valid) |=> $stable(wb_adr_o));
    a_ack_expected: assert property (@(posedge clk) disable iff (!rst_n)
        wb_ack_i |-> (outstanding_q != '0));

endmodule

// File: tb/tb_wb_prefetch.sv
module tb_wb_prefetch;

    localparam int AW    = 13;
    localparam int DEPTH = 4;
    localparam logic [AW-1:0] RESET_PC = '0;

    typedef struct { logic [AW-1:0] a; bit disc; } req_t;
    typedef struct { int due; logic [15:0] dat; } rsp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          insn_valid;
    logic          insn_ready = 1'b0;
    logic [15:0]   insn_data;
    logic [AW-1:0] insn_pc;
    logic          wb_cyc_o, wb_stb_o;
    logic [AW-1:0] wb_adr_o;
    logic [15:0]   wb_dat_i = '0;
    logic          wb_ack_i = 1'b0;
    logic          wb_stall_i = 1'b0;

    always #5 clk = ~clk;

    wb_prefetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .insn_valid     (insn_valid),
        .insn_ready     (insn_ready),
        .insn_data      (insn_data),
        .insn_pc        (insn_pc),
        .wb_cyc_o       (wb_cyc_o),
        .wb_stb_o       (wb_stb_o),
        .wb_adr_o       (wb_adr_o),
        .wb_dat_i       (wb_dat_i),
        .wb_ack_i       (wb_ack_i),
        .wb_stall_i     (wb_stall_i)
    );

    // ROM contents and reference model state.
    logic [15:0]   rom [1<<AW];
    req_t          inflight[$];   // accepted requests awaiting ack, in order
    logic [AW-1:0] buffer[$];     // addresses of words buffered for the CPU
    rsp_t          romq[$];       // pending ROM responses
    logic [AW-1:0] next_addr;     // next address the master should request
    int            tests = 0;
    int            fails = 0;
    int            cyc_n = 0;
    int            last_due = 0;
    int            lat = 1;       // ROM latency; 0 = random 1..3 per request
    int            pops = 0;
    int            pops0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model.
    task automatic cycle(input bit rdy, input bit stl, input bit redir, input logic [AW-1:0] rpc);
        bit   exp_stb;
        req_t e;
        rsp_t r;
        @(negedge clk);
        insn_ready     = rdy;
        wb_stall_i     = stl;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (romq.size() != 0 && romq[0].due <= cyc_n) begin
            wb_ack_i = 1'b1;
            wb_dat_i = romq[0].dat;
            romq.delete(0);
        end else begin
            wb_ack_i = 1'b0;
            wb_dat_i = 16'($urandom);
        end
        #1;
        exp_stb = !redir && ((inflight.size() + buffer.size()) < DEPTH);
        chk("stb", 32'(wb_stb_o), 32'(exp_stb));
        chk("cyc", 32'(wb_cyc_o), 32'(exp_stb || inflight.size() != 0));
        if (exp_stb) chk("adr", 32'(wb_adr_o), 32'(next_addr));
        chk("insn_valid", 32'(insn_valid), 32'(buffer.size() != 0));
        if (buffer.size() != 0) begin
            chk("insn_pc", 32'(insn_pc), 32'(buffer[0]));
            chk("insn_data", 32'(insn_data), 32'(rom[buffer[0]]));
        end
        if (insn_valid && rdy) pops++;

        if (buffer.size() != 0 && rdy) buffer.delete(0);
        if (wb_ack_i && inflight.size() != 0) begin
            e = inflight[0];
            inflight.delete(0);
            if (!redir && !e.disc) buffer.push_back(e.a);
        end
        if (redir) begin
            buffer.delete();
            foreach (inflight[i]) inflight[i].disc = 1'b1;
            next_addr = rpc;
        end else if (exp_stb && !stl) begin
            inflight.push_back('{next_addr, 1'b0});
            next_addr = next_addr + AW'(1);
        end

        if (wb_stb_o && !wb_stall_i) begin
            r.due = cyc_n + ((lat == 0) ? int'($urandom_range(1, 3)) : lat);
            if (r.due <= last_due) r.due = last_due + 1;
            last_due = r.due;
            r.dat    = rom[wb_adr_o];
            romq.push_back(r);
        end
        cyc_n++;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cyc"}, 32'(wb_cyc_o), 32'd0);
        chk({tag, "_stb"}, 32'(wb_stb_o), 32'd0);
        chk({tag, "_adr"}, 32'(wb_adr_o), 32'(RESET_PC));
        chk({tag, "_valid"}, 32'(insn_valid), 32'd0);
    endtask

    // Release reset at a falling edge; the bus must stay idle until the next rising edge.
    task automatic release_reset();
        romq.delete();
        inflight.delete();
        buffer.delete();
        next_addr = RESET_PC;
        last_due  = 0;
        @(negedge clk);
        wb_ack_i = 1'b0; redirect_valid = 1'b0; wb_stall_i = 1'b0;
        rst_n = 1'b1;
        #1;
        check_reset_outputs("release");
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) rom[i] = 16'($urandom);

        // Power-on reset.
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        release_reset();

        // Streaming with a 1-cycle ROM: one word per cycle once warmed up.
        lat = 1;
        for (int i = 0; i < 8; i++) cycle(1, 0, 0, '0);
        pops0 = pops;
        for (int i = 0; i < 16; i++) cycle(1, 0, 0, '0);
        chk("throughput", 32'(pops - pops0), 32'd16);

        // Async reset mid-stream with responses still pending.
        lat = 2;
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, '0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wb_ack_i = (romq.size() != 0);
            if (romq.size() != 0) begin
                wb_dat_i = romq[0].dat;
                romq.delete(0);
            end
            #1;
            chk("in_rst_valid", 32'(insn_valid), 32'd0);
            chk("in_rst_cyc", 32'(wb_cyc_o), 32'd0);
        end
        lat = 1;
        release_reset();

        // CPU stalls: credit stops issue with pc 0..3 buffered, then drains in order.
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, '0);
        chk("full_stb", 32'(wb_stb_o), 32'd0);
        chk("full_valid", 32'(insn_valid), 32'd1);
        chk("full_head_pc", 32'(insn_pc), 32'd0);
        for (int i = 0; i < 12; i++) cycle(1, 0, 0, '0);

        // Slave stall for 3 cycles at address 5.
        cycle(1, 0, 1, AW'(5));
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 0, '0);
            chk("stall_adr", 32'(wb_adr_o), 32'd5);
            chk("stall_stb", 32'(wb_stb_o), 32'd1);
        end
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, '0);

        // Redirect to 0x1000 with two requests outstanding.
        lat = 2;
        for (int i = 0; i < 8; i++) cycle(1, 0, 0, '0);
        lat = 1;
        cycle(1, 0, 1, AW'(13'h1000));
        cycle(1, 0, 0, '0);
        chk("redir_flush", 32'(insn_valid), 32'd0);
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, '0);

        // Address wrap from 0x1FFE; first word at R+3.
        cycle(1, 0, 1, AW'(13'h1FFE));
        cycle(1, 0, 0, '0);
        cycle(1, 0, 0, '0);
        cycle(1, 0, 0, '0);
        chk("wrap_valid", 32'(insn_valid), 32'd1);
        chk("wrap_pc0", 32'(insn_pc), 32'h1FFE);
        cycle(1, 0, 0, '0);
        chk("wrap_pc1", 32'(insn_pc), 32'h1FFF);
        cycle(1, 0, 0, '0);
        chk("wrap_pc2", 32'(insn_pc), 32'h0000);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, '0);

        // Randomized traffic: ready, stall, redirects, variable ROM latency.
        lat = 0;
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 29) == 0, AW'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
